// File: rtl/cache_bus_arbiter.sv
// Arbitrates the system bus between I-cache fills and D-cache fills/writebacks.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is D-cache priority.
module cache_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BITS      = 512
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req,
  input  logic [63:0]               ic_addr,
  output logic [LINE_BITS-1:0]      ic_line,
  output logic [9:0]                ic_offset,
  input  logic                      dc_req,
  input  logic                      dc_we,
  input  logic [63:0]               dc_addr,
  input  logic [LINE_BITS-1:0]      dc_wdata,
  output logic [LINE_BITS-1:0]      dc_line,
  output logic [9:0]                dc_offset,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      busy
);

  localparam int BEATS = LINE_BITS / BUS_DATA_WIDTH;
  localparam logic [BUS_TAG_WIDTH-1:0] TAG_RD = BUS_TAG_WIDTH'(13'h0100);
  localparam logic [BUS_TAG_WIDTH-1:0] TAG_WR = BUS_TAG_WIDTH'(13'h1100);
  localparam logic [63:0] ALIGN_MASK = ~64'(LINE_BITS / 8 - 1);

  typedef enum logic [2:0] {IDLE, REQ, RDATA, WDATA, DONE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [63:0]              addr_q, addr_d;
  logic                     gnt_dc_q, gnt_dc_d;
  logic                     we_q, we_d;
  logic [LINE_BITS-1:0]     wdata_q, wdata_d;
  logic [LINE_BITS-1:0]     ic_line_q, ic_line_d;
  logic [LINE_BITS-1:0]     dc_line_q, dc_line_d;
  logic                     last_dc_q, last_dc_d;

  logic                     pick_dc;
  logic [BUS_TAG_WIDTH-1:0] tag;
  logic [9:0]               prog;
  logic [3:0]               cnt_inc;
  logic                     last_beat;
  int unsigned              base;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    gnt_dc_d  = gnt_dc_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ic_line_d = ic_line_q;
    dc_line_d = dc_line_q;
    last_dc_d = last_dc_q;

    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    ic_offset   = '0;
    dc_offset   = '0;
    prog        = '0;

    tag       = we_q ? TAG_WR : TAG_RD;
    base      = cnt_q * BUS_DATA_WIDTH;
    last_beat = (cnt_q == 4'(BEATS - 1));
    cnt_inc   = (cnt_q == 4'(BEATS)) ? cnt_q : cnt_q + 4'd1;

`ifdef ARB_ROUND_ROBIN_EN
    pick_dc = dc_req && !(ic_req && last_dc_q);
`else
    pick_dc = dc_req;
`endif

    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          gnt_dc_d  = pick_dc;
          we_d      = pick_dc && dc_we;
          addr_d    = (pick_dc ? dc_addr : ic_addr) & ALIGN_MASK;
          last_dc_d = pick_dc;
          cnt_d     = '0;
          if (pick_dc) wdata_d = dc_wdata;
          state_d   = REQ;
        end
      end
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = BUS_DATA_WIDTH'(addr_q);
        bus_reqtag = tag;
        if (bus_reqack) begin
          cnt_d   = '0;
          state_d = we_q ? WDATA : RDATA;
        end
      end
      RDATA: begin
        prog = 10'(base);
        if (bus_respcyc && bus_resptag == tag) begin
          bus_respack = 1'b1;
          if (gnt_dc_q) dc_line_d[base +: BUS_DATA_WIDTH] = bus_resp;
          else          ic_line_d[base +: BUS_DATA_WIDTH] = bus_resp;
          cnt_d = cnt_inc;
          if (last_beat) state_d = DONE;
        end
      end
      WDATA: begin
        prog       = 10'(base);
        bus_reqcyc = 1'b1;
        bus_req    = wdata_q[base +: BUS_DATA_WIDTH];
        bus_reqtag = tag;
        if (bus_reqack) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        prog    = 10'(LINE_BITS);
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Only the granted side reports progress; the other stays at zero.
    if (gnt_dc_q) dc_offset = prog;
    else          ic_offset = prog;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      gnt_dc_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ic_line_q <= '0;
      dc_line_q <= '0;
      last_dc_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      gnt_dc_q  <= gnt_dc_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
      last_dc_q <= last_dc_d;
    end
  end

  assign ic_line = ic_line_q;
  assign dc_line = dc_line_q;
  assign busy    = (state_q != IDLE);

endmodule
